pixel_packer: RTL
=================

Name: pixel_packer

Overview:
- Sits directly downstream of the gradient-magnitude stage.
- Consumes its 4-bit edge pixels (pixel + output_enable) and packs them into 32-bit words, first pixel in the least-significant nibble.
- Buffers the words in a small FIFO and offers them to the output/memory writer over a valid/ready handshake.
- Supports end-of-frame flush with zero padding, and flags words lost to back-pressure.

Parameters:
- PIX_PER_WORD, 8, pixels packed per output word; word width is 4*PIX_PER_WORD = 32.
- FIFO_DEPTH, 4, number of packed words buffered; power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- pixel  input  4  edge pixel from the magnitude stage.
- pixel_valid  input  1  pixel qualifier, driven by the magnitude stage's output_enable.
- flush  input  1  end-of-frame pulse; emit any partial word.
- word_out  output  32  packed word at the FIFO head.
- word_valid  output  1  word_out holds a valid word.
- word_last  output  1  word at the head is the final word of a frame.
- word_ready  input  1  consumer accepts the head word this cycle.
- overflow  output  1  sticky: a completed word was dropped.
- clear_overflow  input  1  synchronous clear of overflow.
- fifo_count  output  3  words currently held, 0..FIFO_DEPTH.

Behaviour:
Interface and reset:
- Reset n_rst is asynchronous, active-low; clock clk.
- On reset: accumulator = 0, nibble count = 0, FIFO empty, word_out = 0, word_valid = 0, word_last = 0, overflow = 0, fifo_count = 0.
- Reset mid-word or mid-frame discards all partial and buffered data.

Packing:
- Every pixel presented with pixel_valid = 1 is accepted; the block never stalls its input.
- The k-th accepted pixel of a word (k = 0..PIX_PER_WORD-1) goes to bits [4k+3:4k].
- On the edge that accepts pixel k = PIX_PER_WORD-1, the completed word is pushed into the FIFO and the count returns to 0.
- The accumulator is cleared to 0 after each push.

Flush:
- On a flush cycle with count > 0 after including any same-cycle pixel, the partial word is pushed. Unfilled nibbles are 0 and the word is tagged last = 1. Count returns to 0.
- Flush with pixel_valid in the same cycle: that pixel is included first. If it completes the word, exactly one word is pushed, tagged last = 1.
- Flush with count = 0 and no same-cycle pixel: no push and no other effect.

FIFO and handshake:
- Entries hold {last, word}.
- word_valid = (fifo_count != 0). word_out and word_last show the head entry combinationally from FIFO storage; word_out = 0 when the FIFO is empty.
- A pop occurs when word_valid & word_ready.
- While word_valid = 1 and word_ready = 0, word_out and word_last hold stable.
- Latency: a word completed at edge N is visible with word_valid = 1 in the cycle after edge N if the FIFO was empty.
- Push and pop in the same cycle: both occur; fifo_count is unchanged.
- Push when full with a simultaneous pop: accepted, no overflow.
- Push when full without a pop: the word is dropped, overflow is set to 1, and FIFO contents are unchanged.
- overflow stays set until clear_overflow = 1. If a new drop coincides with clear_overflow, set wins.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_count saturates logically at FIFO_DEPTH, since a push at full is dropped.

Test Plan:
- Reset, then pixels 1,2,3,4,5,6,7,8 on consecutive cycles with word_ready = 1 -> word_out = 0x87654321, word_valid for exactly 1 cycle starting the cycle after pixel 8, word_last = 0, fifo_count returns to 0.
- Pixels 0xA,0xB,0xC, then flush alone -> word_out = 0x00000CBA, word_last = 1. A second flush immediately after -> no word produced.
- word_ready = 0, feed 5 full words (40 pixels, values 0..F cycling) -> fifo_count = 4, overflow = 1, fifo_count stays 4 while word_valid holds. Raise word_ready -> the first 4 words drain in order; the 5th never appears. Pulse clear_overflow -> overflow = 0.
- FIFO full with word_ready = 1 on the same cycle a new word completes -> no overflow, fifo_count remains 4, and word order is preserved.
- 7 pixels of 0xF, then pixel 0x1 with flush in the same cycle -> single word 0x1FFFFFFF with word_last = 1, no extra padded word.
- Assert n_rst low mid-word (3 pixels accumulated) with 2 words in the FIFO -> word_valid = 0 and fifo_count = 0 immediately. After release, pixels 1..8 produce 0x87654321 with no stale nibbles.

Source files
------------

// File: rtl/pixel_packer_if.sv
// Signal bundle between the edge-pixel source, the pixel packer and the word consumer.
// The master side drives pixels and consumer controls; the slave side (the packer) returns words and status.
interface pixel_packer_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 3
);
    logic [3:0]        pixel;
    logic              pixel_valid;
    logic              flush;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;
    logic              overflow;
    logic              clear_overflow;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output pixel, pixel_valid, flush, word_ready, clear_overflow,
        input  word_out, word_valid, word_last, overflow, fifo_count
    );

    modport slave (
        input  pixel, pixel_valid, flush, word_ready, clear_overflow,
        output word_out, word_valid, word_last, overflow, fifo_count
    );
endinterface

// File: rtl/pixel_packer.sv
// Packs 4-bit edge pixels into words (first pixel in the low nibble) and buffers them
// in a small FIFO with a valid/ready output, end-of-frame flush and a sticky drop flag.
module pixel_packer #(
    parameter int PIX_PER_WORD = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    pixel_packer_if.slave bus
);
    localparam int WORD_W = 4 * PIX_PER_WORD;
    localparam int NIB_W  = $clog2(PIX_PER_WORD);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(PIX_PER_WORD - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [WORD_W-1:0] accWord_q, accWord_d, accMerged;
    logic [NIB_W-1:0]  nibCount_q, nibCount_d;
    logic              wordDone, pushReq, pushLast;

    logic [WORD_W:0]   fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              fifoFull, popEn, pushEn, dropEn;

    // A same-cycle pixel is merged before deciding whether a flush has anything to emit.
    always_comb begin
        accMerged = accWord_q;
        if (bus.pixel_valid) begin
            accMerged = accWord_q | (WORD_W'(bus.pixel) << {nibCount_q, 2'b00});
        end
        wordDone   = bus.pixel_valid && (nibCount_q == LAST_NIB);
        pushReq    = wordDone || (bus.flush && (bus.pixel_valid || (nibCount_q != '0)));
        pushLast   = bus.flush;
        accWord_d  = pushReq ? '0 : accMerged;
        nibCount_d = pushReq ? '0 : nibCount_q + NIB_W'(bus.pixel_valid);
    end

    // A pop frees the head slot this cycle, so a push into a full FIFO may still land.
    always_comb begin
        fifoFull   = (count_q == FULL_CNT);
        popEn      = (count_q != '0) && bus.word_ready;
        pushEn     = pushReq && (!fifoFull || popEn);
        dropEn     = pushReq && fifoFull && !popEn;
        rdPtr_d    = rdPtr_q + PTR_W'(popEn);
        wrPtr_d    = wrPtr_q + PTR_W'(pushEn);
        count_d    = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
        overflow_d = overflow_q;
        if (dropEn) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            accWord_q  <= '0;
            nibCount_q <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            accWord_q  <= accWord_d;
            nibCount_q <= nibCount_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem_q[wrPtr_q] <= {pushLast, accMerged};
        end
    end

    assign bus.word_valid = (count_q != '0);
    assign bus.word_out   = bus.word_valid ? fifoMem_q[rdPtr_q][WORD_W-1:0] : '0;
    assign bus.word_last  = bus.word_valid ? fifoMem_q[rdPtr_q][WORD_W] : 1'b0;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count_q;
endmodule
